fsm_seq_dwell: RTL and testbench

- Parametrised successor of the team's 4-state Moore sequencer (ST0→ST1→{ST2|ST3}→ST3→ST0).
- Generalised to NUM_STATES states with a per-state programmable dwell time, a parametrised skip point, an enable/hold input, registered outputs, state-entry and wrap strobes, and a sticky illegal-state flag.
- Used as a control-phase generator feeding datapath blocks.
- With default parameters and all dwell values 0, the y sequence is identical to the 4-state original.

---
 rtl/fsm_seq_pkg.sv | 21 ++
 rtl/fsm_dwell_cnt.sv | 37 +++
 rtl/fsm_seq_dwell.sv | 112 +++++++++++
 tb/tb_fsm_seq_dwell.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_seq_pkg.sv
// Shared constants and helpers for the dwell-time phase sequencer.
// Everything here is elaboration-time only.
package fsm_seq_pkg;

    localparam int unsigned ST_RESET = 0;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Bit offset of dwell field idx inside the packed dwell_cfg vector.
    function automatic int unsigned dwell_lsb(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/fsm_dwell_cnt.sv
// Per-state dwell counter: match when count equals limit; self-clears on an enabled match.
// Latency: match is combinational from the registered count; enable=0 holds the count.
module fsm_dwell_cnt #(
    parameter int unsigned DWELL_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   clr,
    input  logic [DWELL_WIDTH-1:0] limit,
    output logic                   match
);

    logic [DWELL_WIDTH-1:0] cnt_q;
    logic [DWELL_WIDTH-1:0] cnt_d;

    assign match = (cnt_q == limit);

    // A count already past a lowered limit wraps naturally and matches on the way round.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = match ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fsm_seq_dwell.sv
// Control-phase sequencer: NUM_STATES states, per-state dwell, skip from SKIP_STATE, sticky err.
// Outputs registered from next state (0-cycle latency to new y); enable=0 holds everything.
module fsm_seq_dwell
    import fsm_seq_pkg::*;
#(
    parameter  int unsigned NUM_STATES  = 4,
    parameter  int unsigned DWELL_WIDTH = 4,
    parameter  int unsigned SKIP_STATE  = 1,
    localparam int unsigned STATE_WIDTH = (clog2(NUM_STATES) < 1) ? 1 : clog2(NUM_STATES)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              enable,
    input  logic                              control,
    input  logic [NUM_STATES*DWELL_WIDTH-1:0] dwell_cfg,
    output logic [STATE_WIDTH-1:0]            y,
    output logic [NUM_STATES-1:0]             y_onehot,
    output logic                              state_entry,
    output logic                              wrap,
    output logic                              err
);

    localparam logic [STATE_WIDTH-1:0] SKIP_ST = SKIP_STATE[STATE_WIDTH-1:0];
    localparam logic [STATE_WIDTH-1:0] ST0     = ST_RESET[STATE_WIDTH-1:0];
    localparam logic [STATE_WIDTH:0]   N_EXT   = NUM_STATES[STATE_WIDTH:0];
    localparam logic [STATE_WIDTH:0]   ONE     = 1;
    localparam logic [STATE_WIDTH:0]   TWO     = 2;

    logic [STATE_WIDTH-1:0] state_q, state_d;
    logic [NUM_STATES-1:0]  y_onehot_q, y_onehot_d;
    logic                   state_entry_q, state_entry_d;
    logic                   wrap_q, wrap_d;
    logic                   err_q, err_d;

    logic [DWELL_WIDTH-1:0] cur_limit;
    logic                   legal;
    logic                   cnt_match;
    logic [STATE_WIDTH:0]   step_sum;
    logic [STATE_WIDTH:0]   step_wrapped;
    logic [STATE_WIDTH-1:0] nxt_state;

    assign legal = ({1'b0, state_q} < N_EXT);

    always_comb begin
        cur_limit = '0;
        for (int k = 0; k < NUM_STATES; k++) begin
            if (state_q == STATE_WIDTH'(k)) begin
                cur_limit = dwell_cfg[dwell_lsb(k, DWELL_WIDTH) +: DWELL_WIDTH];
            end
        end
    end

    fsm_dwell_cnt #(
        .DWELL_WIDTH (DWELL_WIDTH)
    ) u_dwell_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (enable & legal),
        .clr   (~legal),
        .limit (cur_limit),
        .match (cnt_match)
    );

    // Sum never exceeds 2*NUM_STATES-1, so a single conditional subtract is a full modulo.
    always_comb begin
        step_sum     = {1'b0, state_q} + (((state_q == SKIP_ST) && control) ? TWO : ONE);
        step_wrapped = (step_sum >= N_EXT) ? (step_sum - N_EXT) : step_sum;
        nxt_state    = step_wrapped[STATE_WIDTH-1:0];
    end

    always_comb begin
        state_d       = state_q;
        err_d         = err_q;
        state_entry_d = 1'b0;
        wrap_d        = 1'b0;
        if (!legal) begin
            // Recovery is unconditional and deliberately not reported as an advance.
            state_d = ST0;
            err_d   = 1'b1;
        end else if (enable && cnt_match) begin
            state_d       = nxt_state;
            state_entry_d = 1'b1;
            wrap_d        = (nxt_state == ST0);
        end
        for (int k = 0; k < NUM_STATES; k++) begin
            y_onehot_d[k] = (state_d == STATE_WIDTH'(k));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST0;
            y_onehot_q    <= NUM_STATES'(1);
            state_entry_q <= 1'b0;
            wrap_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            y_onehot_q    <= y_onehot_d;
            state_entry_q <= state_entry_d;
            wrap_q        <= wrap_d;
            err_q         <= err_d;
        end
    end

    assign y           = state_q;
    assign y_onehot    = y_onehot_q;
    assign state_entry = state_entry_q;
    assign wrap        = wrap_q;
    assign err         = err_q;

endmodule

// File: tb/tb_fsm_seq_dwell.sv
// Bench for fsm_seq_dwell: default 4-state instance against a cycle model, plus a 5-state
// instance for the skip-wrap and illegal-state recovery cases.
module tb_fsm_seq_dwell;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance: 4 states, skip from 1
    logic        reset, enable, control;
    logic [15:0] dwell_cfg;
    logic [1:0]  y;
    logic [3:0]  y_onehot;
    logic        state_entry, wrap, err;

    // Non power-of-two instance: 5 states, skip from 3
    logic        reset_b, enable_b, control_b;
    logic [19:0] dwell_cfg_b;
    logic [2:0]  y_b;
    logic [4:0]  y_onehot_b;
    logic        state_entry_b, wrap_b, err_b;

    fsm_seq_dwell dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .control     (control),
        .dwell_cfg   (dwell_cfg),
        .y           (y),
        .y_onehot    (y_onehot),
        .state_entry (state_entry),
        .wrap        (wrap),
        .err         (err)
    );

    fsm_seq_dwell #(.NUM_STATES(5), .DWELL_WIDTH(4), .SKIP_STATE(3)) dut_b (
        .clk         (clk),
        .reset       (reset_b),
        .enable      (enable_b),
        .control     (control_b),
        .dwell_cfg   (dwell_cfg_b),
        .y           (y_b),
        .y_onehot    (y_onehot_b),
        .state_entry (state_entry_b),
        .wrap        (wrap_b),
        .err         (err_b)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: state index and cycles already spent in it
    int   m_st, m_cnt;
    logic m_entry, m_wrap;

    logic [8:0] obs;
    assign obs = {y, y_onehot, state_entry, wrap, err};

    function automatic logic [8:0] exp_vec();
        return {2'(m_st), 4'(1 << m_st), m_entry, m_wrap, 1'b0};
    endfunction

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_entry = 1'b0; m_wrap = 1'b0;
    endtask

    // One clock edge of the 4-state instance: a state lasts dwell+1 enabled cycles.
    task automatic model_step();
        int lim;
        lim = int'((dwell_cfg >> (4 * m_st)) & 16'hF);
        m_entry = 1'b0;
        m_wrap  = 1'b0;
        if (enable) begin
            if (m_cnt == lim) begin
                m_st    = (m_st == 1 && control) ? (m_st + 2) % 4 : (m_st + 1) % 4;
                m_cnt   = 0;
                m_entry = 1'b1;
                m_wrap  = (m_st == 0);
            end else begin
                m_cnt = (m_cnt + 1) % 16;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_step();
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; control = 1'b0; dwell_cfg = '0;
        reset_b = 1'b1; enable_b = 1'b0; control_b = 1'b0; dwell_cfg_b = '0;
        model_reset();
        #2;
        checks++;
        if (obs !== 9'b00_0001_000) begin
            errors++;
            $display("FAIL reset_a: got %b want %b", obs, 9'b00_0001_000);
        end
        checks++;
        if ({y_b, y_onehot_b, state_entry_b, wrap_b, err_b} !== 11'b000_00001_000) begin
            errors++;
            $display("FAIL reset_b: got %b want %b", {y_b, y_onehot_b, state_entry_b, wrap_b, err_b}, 11'b000_00001_000);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        reset_b = 1'b0;
    endtask

    task automatic test_basic_seq();
        enable = 1'b1; control = 1'b0; dwell_cfg = '0;
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL basic cyc%0d: got %b want %b", i, obs, exp_vec());
            end
            checks++;
            if (y !== 2'((i + 1) % 4)) begin
                errors++;
                $display("FAIL basic_y cyc%0d: got %0d want %0d", i, y, (i + 1) % 4);
            end
        end
    endtask

    task automatic test_skip();
        logic [3:0] oh_tab [3];
        oh_tab[0] = 4'b0010; oh_tab[1] = 4'b1000; oh_tab[2] = 4'b0001;
        enable = 1'b1; control = 1'b1; dwell_cfg = '0;
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec() || y_onehot !== oh_tab[i % 3]) begin
                errors++;
                $display("FAIL skip cyc%0d: got %b want %b (onehot want %b)", i, obs, exp_vec(), oh_tab[i % 3]);
            end
        end
        control = 1'b0;
    endtask

    task automatic test_dwell();
        int run;
        enable = 1'b1; control = 1'b0; dwell_cfg = 16'h0300;
        apply_reset();
        run = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL dwell cyc%0d: got %b want %b", i, obs, exp_vec());
            end
            if (i < 7 && y == 2'd2) run++;
        end
        checks++;
        if (run != 4) begin
            errors++;
            $display("FAIL dwell_len: got %0d cycles in state 2, want 4", run);
        end
    endtask

    task automatic test_enable_hold();
        int guard, run;
        enable = 1'b1; control = 1'b0; dwell_cfg = 16'h0300;
        apply_reset();
        guard = 0;
        while (y != 2'd2 && guard < 10) begin
            tick();
            guard++;
        end
        checks++;
        if (y != 2'd2) begin
            errors++;
            $display("FAIL hold_reach: got y=%0d want 2 within 10 cycles", y);
        end
        tick();
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec() || y !== 2'd2 || state_entry !== 1'b0 || wrap !== 1'b0) begin
                errors++;
                $display("FAIL hold cyc%0d: got %b want %b", i, obs, exp_vec());
            end
        end
        enable = 1'b1;
        run = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL resume cyc%0d: got %b want %b", i, obs, exp_vec());
            end
            if (y == 2'd2) run++;
        end
        checks++;
        if (run != 2 || y !== 2'd3) begin
            errors++;
            $display("FAIL resume_len: got %0d cycles of 2 then y=%0d, want 2 then y=3", run, y);
        end
    endtask

    task automatic test_cfg_wrap();
        int guard;
        enable = 1'b1; control = 1'b0; dwell_cfg = 16'h0500;
        apply_reset();
        guard = 0;
        while (y != 2'd2 && guard < 10) begin
            tick();
            guard++;
        end
        for (int i = 0; i < 3; i++) tick();
        dwell_cfg = 16'h0100;
        for (int i = 0; i < 18; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL cfg_wrap cyc%0d: got %b want %b", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        enable = 1'b1; control = 1'b0; dwell_cfg = 16'h0033;
        apply_reset();
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (obs !== exp_vec() || y !== 2'd1) begin
            errors++;
            $display("FAIL pre_areset: got %b want %b", obs, exp_vec());
        end
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (obs !== 9'b00_0001_000) begin
            errors++;
            $display("FAIL areset_now: got %b want %b", obs, 9'b00_0001_000);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec() || y !== ((i < 3) ? 2'd0 : 2'd1)) begin
                errors++;
                $display("FAIL post_areset cyc%0d: got %b want %b", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] cfg;
        enable = 1'b1; control = 1'b0; dwell_cfg = '0;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            enable  = ($urandom_range(0, 3) != 0);
            control = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) begin
                if ($urandom_range(0, 7) == 0) begin
                    cfg = 16'($urandom);
                end else begin
                    for (int k = 0; k < 4; k++) cfg[k*4 +: 4] = 4'($urandom_range(0, 3));
                end
                dwell_cfg = cfg;
            end
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc%0d: got %b want %b cfg=%h", i, obs, exp_vec(), dwell_cfg);
            end
        end
        enable = 1'b1; control = 1'b0;
    endtask

    task automatic test_nonpow2_illegal();
        logic [2:0] exp_y [5];
        exp_y[0] = 3'd1; exp_y[1] = 3'd2; exp_y[2] = 3'd3; exp_y[3] = 3'd0; exp_y[4] = 3'd1;
        enable_b = 1'b1; control_b = 1'b1; dwell_cfg_b = '0;
        @(negedge clk);
        reset_b = 1'b1;
        @(posedge clk);
        #1;
        reset_b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (y_b !== exp_y[i] || y_onehot_b !== 5'(1 << exp_y[i]) || wrap_b !== (exp_y[i] == 3'd0)
                || state_entry_b !== 1'b1 || err_b !== 1'b0) begin
                errors++;
                $display("FAIL n5_seq cyc%0d: got y=%0d oh=%b se=%b wr=%b err=%b want y=%0d",
                         i, y_b, y_onehot_b, state_entry_b, wrap_b, err_b, exp_y[i]);
            end
        end
        enable_b = 1'b0;
        force dut_b.state_q = 3'd6;
        #1;
        release dut_b.state_q;
        @(posedge clk);
        #1;
        checks++;
        if ({y_b, y_onehot_b, state_entry_b, wrap_b, err_b} !== 11'b000_00001_001) begin
            errors++;
            $display("FAIL n5_recover: got %b want %b", {y_b, y_onehot_b, state_entry_b, wrap_b, err_b}, 11'b000_00001_001);
        end
        @(posedge clk);
        #1;
        checks++;
        if (y_b !== 3'd0 || err_b !== 1'b1 || state_entry_b !== 1'b0) begin
            errors++;
            $display("FAIL n5_hold: got y=%0d err=%b se=%b want y=0 err=1 se=0", y_b, err_b, state_entry_b);
        end
        enable_b = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (y_b !== 3'd1 || err_b !== 1'b1 || state_entry_b !== 1'b1) begin
            errors++;
            $display("FAIL n5_sticky: got y=%0d err=%b se=%b want y=1 err=1 se=1", y_b, err_b, state_entry_b);
        end
        #2;
        reset_b = 1'b1;
        #1;
        checks++;
        if (err_b !== 1'b0 || y_b !== 3'd0) begin
            errors++;
            $display("FAIL n5_err_clear: got err=%b y=%0d want err=0 y=0", err_b, y_b);
        end
        @(posedge clk);
        #1;
        reset_b = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic_seq();
        test_skip();
        test_dwell();
        test_enable_hold();
        test_cfg_wrap();
        test_async_reset();
        test_random();
        test_nonpow2_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
